ula_muldiv: RTL and testbench
=============================

ULA_MULDIV -- requirements
Module: ula_muldiv

Interface
REQ-001 The block SHALL have parameter: WIDTH, 32, operand/HI/LO width (even, >= 4).
REQ-002 The block SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports: start  input  1  request an operation; sampled only in IDLE.
REQ-005 The block SHALL have ports: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports: a  input  WIDTH  first operand / dividend.
REQ-007 The block SHALL have ports: b  input  WIDTH  second operand / divisor.
REQ-008 The block SHALL have ports: mthi, mtlo  input  1 each  direct write of wdata into HI / LO.
REQ-009 The block SHALL have ports: wdata  input  WIDTH  data for mthi/mtlo.
REQ-010 The block SHALL have ports: busy  output  1  operation in progress.
REQ-011 The block SHALL have ports: done  output  1  one-cycle pulse, HI/LO hold new result.
REQ-012 The block SHALL have ports: div_zero  output  1  last DIV/DIVU had b == 0; held until next start.
REQ-013 The block SHALL have ports: hi, lo  output  WIDTH each  registered result registers.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, SIGN; busy = 1 exactly in CALC and SIGN.
REQ-015 IDLE with start = 1 SHALL latch op and operand magnitudes (absolute values for MULT/DIV, raw for MULTU/DIVU) plus result sign bits, clear the iteration counter, and go to CALC.
REQ-016 CALC SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly WIDTH cycles, then go to SIGN.
REQ-017 SIGN SHALL apply sign correction, write hi/lo, assert done in the following cycle, and return to IDLE.
REQ-018 Latency: start sampled at edge N SHALL produce new hi/lo and done = 1 in the cycle after edge N+WIDTH+1; busy is high for WIDTH+1 cycles.
REQ-019 MULT/MULTU SHALL give {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
REQ-020 DIV/DIVU SHALL give lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-021 Divide by zero SHALL give lo = all ones, hi = a, div_zero = 1, with the same latency as a normal divide.
REQ-022 Signed overflow (a = most negative, b = -1) SHALL give lo = most negative, hi = 0, div_zero = 0.
REQ-023 start while busy SHALL be ignored, not queued; a, b, op changes while busy SHALL not affect the result.
REQ-024 start in the same cycle that done is high SHALL be accepted (FSM is already in IDLE).
REQ-025 mthi/mtlo in IDLE without start SHALL write wdata to hi/lo at that edge; mthi and mtlo together write both.
REQ-026 mthi/mtlo while busy, or in the same cycle as an accepted start, SHALL be ignored.
REQ-027 hi/lo SHALL hold their value in all cycles not covered by REQ-017/REQ-025.

Reset
REQ-028 rst_n = 0 SHALL immediately force IDLE, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, counter = 0, including mid-operation; the aborted operation produces no done.
REQ-029 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-030 WIDTH=32, MULT a=0xFFFFFFFE (-2), b=3 at edge 0 -> busy for 33 cycles, done after edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-032 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1; next DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-033 start pulsed again 5 cycles into a MULT with different operands -> ignored, first result unchanged; start held through done -> second op accepted back-to-back.
REQ-034 mthi wdata=0x1234 in IDLE -> hi=0x1234 next cycle; mtlo during busy -> lo unchanged, final result written.
REQ-035 rst_n low at CALC cycle 10 -> busy=0, hi=lo=0 asynchronously, no done pulse; WIDTH=8 regression: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 busy cycles.

Source files
------------

// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative multiply/divide unit with HI/LO result registers.
//   One radix-2 step per cycle for WIDTH cycles. After that, one cycle of
//   sign correction writes hi/lo. done pulses in the cycle after that write.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b              operands (multiplicands, or dividend/divisor)
//   mthi, mtlo, wdata direct writes of hi/lo while idle
//   busy, done        operation in progress / one-cycle completion pulse
//   div_zero          last divide had a zero divisor (held until next start)
//   hi, lo            result registers
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, b_zero;
  logic [WIDTH-1:0] opd;       // multiplicand or divisor magnitude
  logic [WIDTH:0]   acc_hi;    // partial product high half / remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend-quotient bits

  // operand magnitudes; the most negative value maps to itself, which is
  // already the correct unsigned magnitude
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s;

  always_comb begin
    mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, opd} : '0);
    div_sh   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    // top bit set means the trial subtraction borrowed
    div_diff = {1'b0, div_sh} - {2'b00, opd};
    prod     = {acc_hi[WIDTH-1:0], acc_lo};
    prod_s   = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
    q_s      = neg_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
    r_s      = neg_r ? (~acc_hi[WIDTH-1:0] + WIDTH'(1)) : acc_hi[WIDTH-1:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and status
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nx = SIGN;
      end
      SIGN: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      opd      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            b_zero   <= (b == '0);
            opd      <= b_mag;
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            cnt      <= '0;
            div_zero <= 1'b0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
              acc_hi <= div_diff[WIDTH:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_sh;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        SIGN: begin
          done <= 1'b1;
          if (is_div) begin
            // a zero divisor leaves the dividend as the remainder, so hi
            // needs no special case; only the quotient is forced
            lo       <= b_zero ? '1 : q_s;
            hi       <= r_s;
            div_zero <= b_zero;
          end else begin
            {hi, lo} <= prod_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv.sv
module tb_ula_muldiv;

  typedef longint unsigned u64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start32, start8, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;

  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ula_muldiv #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  ula_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .mthi(1'b0), .mtlo(1'b0), .wdata(wdata[7:0]),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // arithmetic reference: signed/unsigned product, truncating division
  function automatic void model(input int w, input logic [1:0] o, input u64 x, input u64 y,
                                output u64 mh, output u64 ml, output bit mdz);
    u64     m = (u64'(1) << w) - 1;
    longint sx, sy;
    u64     p;
    sx  = (!o[0] && x[w-1]) ? longint'(x) - longint'(u64'(1) << w) : longint'(x);
    sy  = (!o[0] && y[w-1]) ? longint'(y) - longint'(u64'(1) << w) : longint'(y);
    mdz = 1'b0;
    if (!o[1]) begin
      p  = o[0] ? x * y : u64'(sx * sy);
      ml = p & m;
      mh = (p >> w) & m;
    end else if (y == 0) begin
      ml  = m;
      mh  = x;
      mdz = 1'b1;
    end else if (o[0]) begin
      ml = x / y;
      mh = x % y;
    end else begin
      ml = u64'(sx / sy) & m;
      mh = u64'(sx % sy) & m;
    end
  endfunction

  // wait for done on the chosen instance, counting busy cycles on the way
  task automatic wait_done(input bit sm, output int nb, output bit seen);
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sm ? done8 : done32) begin
        seen = 1'b1;
        break;
      end
      if (sm ? busy8 : busy32) nb++;
    end
  endtask

  task automatic run_op(input bit sm, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input string tag);
    u64          eh, el;
    bit          edz, seen;
    int          nb, w;
    logic [31:0] xm, ym;
    w  = sm ? 8 : 32;
    xm = sm ? {24'h0, x[7:0]} : x;
    ym = sm ? {24'h0, y[7:0]} : y;
    model(w, o, u64'(xm), u64'(ym), eh, el, edz);
    @(negedge clk);
    op = o; a = xm; b = ym;
    if (sm) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0; start32 = 1'b0;
    wait_done(sm, nb, seen);
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_busy"}, 64'(nb), 64'(w + 1));
    check({tag, "_hi"}, sm ? 64'(hi8) : 64'(hi32), eh);
    check({tag, "_lo"}, sm ? 64'(lo8) : 64'(lo32), el);
    check({tag, "_dz"}, sm ? 64'(dz8) : 64'(dz32), 64'(edz));
    @(negedge clk);
    check({tag, "_pulse"}, sm ? 64'(done8) : 64'(done32), 64'd0);
  endtask

  logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    u64          eh, el;
    bit          edz, seen;
    int          nb, ndone;
    logic [31:0] saved;

    rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    #12;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_dz", 64'(dz32), 64'd0);
    check("rst_hi", 64'(hi32), 64'd0);
    check("rst_lo", 64'(lo32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed arithmetic cases
    run_op(0, 2'b00, 32'hFFFFFFFE, 32'd3, "mult_m2x3");
    check("mult_m2x3_const", {32'(hi32), 32'(lo32)}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    check("multu_max_const", {32'(hi32), 32'(lo32)}, 64'hFFFFFFFE_00000001);
    run_op(0, 2'b10, 32'hFFFFFFF9, 32'd2, "div_m7d2");
    check("div_m7d2_const", {32'(hi32), 32'(lo32)}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(0, 2'b11, 32'd100, 32'd0, "divu_zero");
    check("divu_zero_const", {32'(hi32), 32'(lo32)}, 64'h00000064_FFFFFFFF);
    run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    check("div_ovf_const", {32'(hi32), 32'(lo32)}, 64'h00000000_80000000);
    run_op(0, 2'b10, 32'hFFFFFFF9, 32'd0, "div_neg_zero");

    // start while busy ignored; start held through done accepted back-to-back
    @(negedge clk);
    op = 2'b00; a = 32'd5; b = 32'hFFFFFFF9; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (5) @(negedge clk);
    op = 2'b11; a = 32'd1000; b = 32'd7; start32 = 1'b1;
    wait_done(0, nb, seen);
    check("ign_done", 64'(seen), 64'd1);
    model(32, 2'b00, 64'd5, 64'hFFFFFFF9, eh, el, edz);
    check("ign_hi", 64'(hi32), eh);
    check("ign_lo", 64'(lo32), el);
    @(posedge clk);
    #1 start32 = 1'b0;
    check("b2b_accept", 64'(busy32), 64'd1);
    wait_done(0, nb, seen);
    check("b2b_busy", 64'(nb), 64'd33);
    check("b2b_hi", 64'(hi32), 64'd6);
    check("b2b_lo", 64'(lo32), 64'd142);

    // direct hi/lo writes
    @(negedge clk);
    saved = lo32;
    mthi = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1 mthi = 1'b0;
    check("mthi_hi", 64'(hi32), 64'h1234);
    check("mthi_lo_keep", 64'(lo32), 64'(saved));
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0F0F;
    @(posedge clk);
    #1 mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", 64'(hi32), 64'hA5A50F0F);
    check("mthilo_lo", 64'(lo32), 64'hA5A50F0F);
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd4; start32 = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1 start32 = 1'b0; mtlo = 1'b0;
    check("mtlo_start_lo", 64'(lo32), 64'hA5A50F0F);
    repeat (3) @(negedge clk);
    mtlo = 1'b1; wdata = 32'hBEEF;
    @(posedge clk);
    #1 mtlo = 1'b0;
    check("mtlo_busy_lo", 64'(lo32), 64'hA5A50F0F);
    wait_done(0, nb, seen);
    check("mtlo_res_done", 64'(seen), 64'd1);
    check("mtlo_res", {32'(hi32), 32'(lo32)}, 64'd12);

    // reset in the middle of an operation
    @(negedge clk);
    op = 2'b10; a = 32'h8123_4567; b = 32'd3; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy32), 64'd0);
    check("arst_hi", 64'(hi32), 64'd0);
    check("arst_lo", 64'(lo32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);

    // start accepted on the first edge after reset release
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1; op = 2'b11; a = 32'd50; b = 32'd5; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    check("rel_accept", 64'(busy32), 64'd1);
    wait_done(0, nb, seen);
    check("rel_busy", 64'(nb), 64'd33);
    check("rel_res", {32'(hi32), 32'(lo32)}, 64'd10);

    // narrow instance
    run_op(1, 2'b01, 32'hFF, 32'hFF, "w8_multu");
    check("w8_multu_const", {48'h0, hi8, lo8}, 64'hFE01);
    run_op(1, 2'b10, 32'h80, 32'hFF, "w8_div_ovf");

    // randomized against the reference model
    for (int i = 0; i < 30; i++)
      run_op(0, 2'($urandom_range(0, 3)), pick(), pick(), $sformatf("rnd32_%0d", i));
    for (int i = 0; i < 20; i++)
      run_op(1, 2'($urandom_range(0, 3)), pick(), pick(), $sformatf("rnd8_%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
